// File: rtl/servo_pkg.sv
// servo_pkg: definitions shared by the servo_ramp slew limiter and its helpers.
//   - register offsets within the four-byte window
//   - STATUS / CTRL bit positions
//   - ramp controller state encoding
//   - step_toward(): one-LSB move of a position toward a target, saturating
package servo_pkg;

  localparam logic [1:0] REG_TARGET   = 2'd0;
  localparam logic [1:0] REG_RATE     = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_POSITION = 2'd3;

  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;
  localparam int CTRL_SNAP_BIT     = 0;
  localparam int CTRL_DONE_CLR_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } ramp_state_t;

  // Moves one LSB toward tgt and never past it, so 0 and 255 are endpoints
  // rather than wrap points.
  function automatic logic [7:0] step_toward(input logic [7:0] pos,
                                             input logic [7:0] tgt);
    logic [7:0] next_pos;
    next_pos = pos;
    if (tgt > pos) begin
      next_pos = pos + 8'd1;
    end else if (tgt < pos) begin
      next_pos = pos - 8'd1;
    end
    return next_pos;
  endfunction

endpackage

// File: rtl/servo_ramp_tick_gen.sv
// tick_gen: free-running prescaler that emits a one-cycle tick.
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset, clears the count
//   tick  out high for the single cycle in which the count sits at
//             TERMINAL_COUNT; the count then wraps to 0
// The period is TERMINAL_COUNT + 1 clocks. Generic enough for any timer block.
module tick_gen #(
  parameter int unsigned TERMINAL_COUNT = 15999
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // A terminal count of 0 would give a zero-width counter; keep one bit.
  localparam int unsigned WIDTH = (TERMINAL_COUNT > 0) ? $clog2(TERMINAL_COUNT + 1) : 1;
  localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL_COUNT);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == TC) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign tick = (count == TC);

endmodule

// File: rtl/servo_ramp.sv
// servo_ramp: memory-mapped slew-rate limiter in front of the servo PWM.
// Software writes TARGET and RATE (ticks per step); position walks toward
// the target one LSB per RATE ticks and raises a sticky done flag on arrival.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   din       in   [7:0] bus write data
//   address   in   [7:0] bus address, window SERVO_RAMP_ADDRESS .. +3
//   w_en      in   write strobe, one cycle per access
//   r_en      in   read strobe, one cycle per access
//   dout      out  [7:0] registered read data, valid the cycle after r_en
//   position  out  [7:0] ramped angle driving the PWM angle input
//   done_irq  out  level interrupt, mirrors the done flag
// Registers: +0 TARGET rw, +1 RATE rw, +2 STATUS r {busy,done} / CTRL w
// {snap,done-clear}, +3 POSITION r.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int unsigned F_CPU              = 16000000,
  parameter int unsigned TICK_US            = 1000,
  parameter logic [7:0]  SERVO_RAMP_ADDRESS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic [7:0] position,
  output logic       done_irq
);

  localparam int unsigned PRESCALE_TC = F_CPU / 32'd1000000 * TICK_US - 1;

  ramp_state_t state, state_next;
  logic [7:0]  target, rate, step_cnt;
  logic [7:0]  position_next, step_next, stepped_pos, read_data, offset;
  logic        done, done_set, done_clr, tick, hit, step_due;
  logic        wr_target, wr_rate, wr_ctrl, rd_status, snap;
  logic [1:0]  reg_sel;

  tick_gen #(.TERMINAL_COUNT(PRESCALE_TC)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // The offset subtraction wraps, so a window placed at the top of the map
  // still decodes as four consecutive addresses.
  assign offset    = address - SERVO_RAMP_ADDRESS;
  assign hit       = (offset < 8'd4);
  assign reg_sel   = offset[1:0];
  assign wr_target = w_en && hit && (reg_sel == REG_TARGET);
  assign wr_rate   = w_en && hit && (reg_sel == REG_RATE);
  assign wr_ctrl   = w_en && hit && (reg_sel == REG_CTRL);
  assign rd_status = r_en && hit && (reg_sel == REG_STATUS);
  assign snap      = wr_ctrl && din[CTRL_SNAP_BIT];
  assign done_clr  = (wr_ctrl && din[CTRL_DONE_CLR_BIT]) || rd_status;

  // ">=" rather than "==" so lowering RATE below the ticks already counted
  // fires on the next tick; RATE = 0 mid-slew therefore steps every tick.
  assign step_due    = ({1'b0, step_cnt} + 9'd1) >= {1'b0, rate};
  assign stepped_pos = step_toward(position, target);

  // A TARGET write or snap owns the cycle: any step due on the same edge is
  // dropped because the write restarts the step counter.
  always_comb begin
    state_next    = state;
    position_next = position;
    step_next     = step_cnt;
    done_set      = 1'b0;
    if (wr_target) begin
      step_next = '0;
      if (din == position) begin
        if (state == SLEW) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end else if (rate == 8'd0) begin
        position_next = din;
        state_next    = IDLE;
        done_set      = 1'b1;
      end else begin
        state_next = SLEW;
      end
    end else if (snap) begin
      position_next = target;
      step_next     = '0;
      state_next    = IDLE;
    end else if ((state == SLEW) && tick) begin
      if (step_due) begin
        step_next     = '0;
        position_next = stepped_pos;
        if (stepped_pos == target) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end else begin
        step_next = step_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      position <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_next;
      position <= position_next;
      step_cnt <= step_next;
    end
  end

  always_comb begin
    read_data = '0;
    case (reg_sel)
      REG_TARGET:   read_data = target;
      REG_RATE:     read_data = rate;
      REG_STATUS: begin
        read_data[STATUS_BUSY_BIT] = (state == SLEW);
        read_data[STATUS_DONE_BIT] = done;
      end
      REG_POSITION: read_data = position;
      default:      read_data = '0;
    endcase
  end

  // Done is cleared by a STATUS read only after dout has captured it, and a
  // set on the same edge as any clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
      rate   <= '0;
      done   <= 1'b0;
      dout   <= '0;
    end else begin
      if (wr_target) begin
        target <= din;
      end
      if (wr_rate) begin
        rate <= din;
      end
      if (done_set) begin
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
      if (r_en) begin
        dout <= hit ? read_data : 8'h00;
      end
    end
  end

  assign done_irq = done;

endmodule

// File: tb/tb_servo_ramp.sv
// tb_servo_ramp: self-checking bench for servo_ramp at F_CPU=1 MHz,
// TICK_US=10 (one tick every 10 clk). Directed scenario tasks plus a
// randomized bus sequence compared against a behavioural model.
module tb_servo_ramp;

  localparam logic [7:0] BASE       = 8'h00;
  localparam logic [7:0] A_TARGET   = BASE;
  localparam logic [7:0] A_RATE     = BASE + 8'd1;
  localparam logic [7:0] A_STATUS   = BASE + 8'd2;
  localparam logic [7:0] A_POSITION = BASE + 8'd3;
  localparam int         TICK_CLKS  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] address = 8'h00;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] dout, position;
  logic       done_irq;

  int checks = 0;
  int errors = 0;

  servo_ramp #(
    .F_CPU              (1000000),
    .TICK_US            (10),
    .SERVO_RAMP_ADDRESS (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .address  (address),
    .w_en     (w_en),
    .r_en     (r_en),
    .dout     (dout),
    .position (position),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: the time since reset fixes the tick phase, and each
  // edge applies the register-map rules to the values held before the edge.
  int m_target, m_rate, m_pos, m_dout, m_done, m_moving, m_wait, m_edges;
  int o_target, o_rate, o_pos, o_done, o_moving, o_off;
  bit o_tick, o_set, o_clr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_target = 0; m_rate = 0; m_pos = 0; m_dout = 0;
      m_done = 0; m_moving = 0; m_wait = 0; m_edges = 0;
    end else begin
      o_off    = (int'(address) - int'(BASE) + 256) % 256;
      o_tick   = (m_edges % TICK_CLKS) == (TICK_CLKS - 1);
      m_edges  = m_edges + 1;
      o_target = m_target; o_rate = m_rate; o_pos = m_pos;
      o_done   = m_done;   o_moving = m_moving;
      o_set    = 1'b0;
      if (r_en) begin
        case (o_off)
          0:       m_dout = o_target;
          1:       m_dout = o_rate;
          2:       m_dout = o_done * 2 + o_moving;
          3:       m_dout = o_pos;
          default: m_dout = 0;
        endcase
      end
      o_clr = (r_en && o_off == 2) || (w_en && o_off == 2 && din[1]);
      if (w_en && o_off == 0) begin
        m_target = int'(din);
        m_wait   = 0;
        if (int'(din) == o_pos) begin
          if (o_moving != 0) begin m_moving = 0; o_set = 1'b1; end
        end else if (o_rate == 0) begin
          m_pos = int'(din); m_moving = 0; o_set = 1'b1;
        end else begin
          m_moving = 1;
        end
      end else if (w_en && o_off == 2 && din[0]) begin
        m_pos = o_target; m_wait = 0; m_moving = 0;
      end else if (o_moving != 0 && o_tick) begin
        if (m_wait + 1 >= o_rate) begin
          m_wait = 0;
          if (o_target > o_pos) m_pos = o_pos + 1;
          else if (o_target < o_pos) m_pos = o_pos - 1;
          if (m_pos == o_target) begin m_moving = 0; o_set = 1'b1; end
        end else begin
          m_wait = m_wait + 1;
        end
      end
      if (w_en && o_off == 1) m_rate = int'(din);
      if (o_set) m_done = 1;
      else if (o_clr) m_done = 0;
    end
  end

  // Bus helpers are entered and left on a falling edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d = dout;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    repeat (3) @(negedge clk);
    checks++; if (position !== 8'h00) begin errors++; $display("[TB] FAIL reset_position: got %0h want 00", position); end
    checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %0h want 00", dout); end
    checks++; if (done_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", done_irq); end
    rst = 1'b0;
    @(negedge clk);
    bus_write(A_TARGET, 8'd3);
    bus_write(A_RATE, 8'd1);
    bus_write(A_TARGET, 8'd60);
    repeat (35) @(negedge clk);
    bus_read(A_TARGET, rd);
    checks++; if (rd !== 8'd60) begin errors++; $display("[TB] FAIL pre_reset_read: got %0h want 3c", rd); end
    checks++; if (!(position > 8'd3 && position < 8'd60)) begin errors++; $display("[TB] FAIL pre_reset_slewing: got %0d want 4..59", position); end
    checks++; if (done_irq !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_done: got %0b want 1", done_irq); end
    #2 rst = 1'b1;
    #1;
    checks++; if (position !== 8'h00) begin errors++; $display("[TB] FAIL async_reset_position: got %0h want 00", position); end
    checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL async_reset_dout: got %0h want 00", dout); end
    checks++; if (done_irq !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_done: got %0b want 0", done_irq); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp_up();
    logic [7:0] rd;
    int last, last_change;
    bit reached;
    bus_write(A_RATE, 8'd2);
    bus_write(A_TARGET, 8'd5);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("[TB] FAIL ramp_busy: got %0h want 01", rd); end
    last = 0; last_change = -1; reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      checks++; if (int'(position) != m_pos) begin errors++; $display("[TB] FAIL ramp_model: got %0d want %0d", position, m_pos); end
      if (int'(position) != last) begin
        checks++; if (int'(position) != last + 1) begin errors++; $display("[TB] FAIL ramp_step: got %0d want %0d", position, last + 1); end
        if (last_change >= 0) begin
          checks++; if (c - last_change != 20) begin errors++; $display("[TB] FAIL ramp_gap: got %0d want 20 clk", c - last_change); end
        end
        checks++; if (done_irq !== (position == 8'd5)) begin errors++; $display("[TB] FAIL ramp_done_edge: got %0b at position %0d", done_irq, position); end
        if (position == 8'd5) reached = 1'b1;
        last = int'(position); last_change = c;
      end
    end
    checks++; if (!reached) begin errors++; $display("[TB] FAIL ramp_timeout: got position %0d want 5", position); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("[TB] FAIL ramp_status: got %0h want 02", rd); end
    checks++; if (done_irq !== 1'b0) begin errors++; $display("[TB] FAIL ramp_done_clear: got %0b want 0", done_irq); end
  endtask

  task automatic test_rate_zero();
    bus_write(A_RATE, 8'd0);
    bus_write(A_TARGET, 8'd200);
    checks++; if (position !== 8'd200) begin errors++; $display("[TB] FAIL rate0_position: got %0d want 200", position); end
    checks++; if (done_irq !== 1'b1) begin errors++; $display("[TB] FAIL rate0_done: got %0b want 1", done_irq); end
    bus_write(A_STATUS, 8'h02);
    checks++; if (done_irq !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_done_clear: got %0b want 0", done_irq); end
  endtask

  task automatic test_retarget();
    int last, rises, moves, lowest;
    logic prev_done;
    bus_write(A_TARGET, 8'd0);
    bus_write(A_STATUS, 8'h02);
    bus_write(A_RATE, 8'd1);
    bus_write(A_TARGET, 8'd10);
    for (int c = 0; c < 100 && position != 8'd4; c++) @(negedge clk);
    checks++; if (position !== 8'd4) begin errors++; $display("[TB] FAIL retarget_reach4: got %0d want 4", position); end
    bus_write(A_TARGET, 8'd2);
    last = 4; rises = 0; moves = 0; lowest = 4; prev_done = done_irq;
    if (done_irq) rises = 1;
    for (int c = 0; c < 80; c++) begin
      if (int'(position) != last) begin
        moves++;
        checks++; if (int'(position) != last - 1) begin errors++; $display("[TB] FAIL retarget_dir: got %0d want %0d", position, last - 1); end
        last = int'(position);
        if (last < lowest) lowest = last;
      end
      if (done_irq && !prev_done) rises++;
      prev_done = done_irq;
      @(negedge clk);
    end
    checks++; if (position !== 8'd2) begin errors++; $display("[TB] FAIL retarget_final: got %0d want 2", position); end
    checks++; if (lowest != 2) begin errors++; $display("[TB] FAIL retarget_overshoot: got min %0d want 2", lowest); end
    checks++; if (moves != 2) begin errors++; $display("[TB] FAIL retarget_moves: got %0d want 2", moves); end
    checks++; if (rises != 1) begin errors++; $display("[TB] FAIL retarget_done_once: got %0d want 1", rises); end
  endtask

  task automatic test_boundaries();
    logic [7:0] rd;
    bit moved;
    bus_write(A_STATUS, 8'h02);
    bus_write(A_RATE, 8'd0);
    bus_write(A_TARGET, 8'd250);
    bus_write(A_STATUS, 8'h02);
    bus_write(A_RATE, 8'd1);
    bus_write(A_TARGET, 8'd255);
    for (int c = 0; c < 100 && !done_irq; c++) @(negedge clk);
    checks++; if (position !== 8'd255 || done_irq !== 1'b1) begin errors++; $display("[TB] FAIL top_reach: got %0d/%0b want 255/1", position, done_irq); end
    moved = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (position != 8'd255) moved = 1'b1;
    end
    checks++; if (moved) begin errors++; $display("[TB] FAIL top_no_wrap: got %0d want 255", position); end
    bus_write(A_TARGET, 8'd255);
    checks++; if (done_irq !== 1'b1) begin errors++; $display("[TB] FAIL same_target_done_kept: got %0b want 1", done_irq); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("[TB] FAIL same_target_idle: got %0h want 02", rd); end
    bus_write(A_TARGET, 8'd255);
    checks++; if (done_irq !== 1'b0) begin errors++; $display("[TB] FAIL same_target_no_set: got %0b want 0", done_irq); end
    bus_write(A_TARGET, 8'd0);
    repeat (25) @(negedge clk);
    checks++; if (!(position < 8'd255 && position > 8'd0)) begin errors++; $display("[TB] FAIL down_slewing: got %0d want 1..254", position); end
    bus_write(A_STATUS, 8'h01);
    checks++; if (position !== 8'd0) begin errors++; $display("[TB] FAIL snap_position: got %0d want 0", position); end
    checks++; if (done_irq !== 1'b0) begin errors++; $display("[TB] FAIL snap_no_done: got %0b want 0", done_irq); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL snap_status: got %0h want 00", rd); end
  endtask

  task automatic test_bus_decode();
    logic [7:0] rd;
    bus_write(A_RATE, 8'd0);
    bus_write(A_TARGET, 8'hA5);
    bus_read(BASE + 8'd4, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL decode_out_of_range: got %0h want 00", rd); end
    address = A_TARGET; r_en = 1'b1;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL read_latency_early: got %0h want 00", dout); end
    @(negedge clk);
    r_en = 1'b0;
    checks++; if (dout !== 8'hA5) begin errors++; $display("[TB] FAIL read_target: got %0h want a5", dout); end
    repeat (3) @(negedge clk);
    checks++; if (dout !== 8'hA5) begin errors++; $display("[TB] FAIL dout_hold: got %0h want a5", dout); end
    bus_read(BASE + 8'd4, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("[TB] FAIL decode_clear: got %0h want 00", rd); end
    bus_write(A_POSITION, 8'h11);
    bus_read(A_POSITION, rd);
    checks++; if (rd !== 8'hA5 || position !== 8'hA5) begin errors++; $display("[TB] FAIL position_write_ignored: got %0h/%0h want a5", rd, position); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("[TB] FAIL status_after_rate0: got %0h want 02", rd); end
    bus_write(A_RATE, 8'd1);
    bus_write(A_TARGET, 8'hA6);
    for (int i = 0; i < 12 && (m_edges % TICK_CLKS) != TICK_CLKS - 1; i++) @(negedge clk);
    checks++; if (position !== 8'hA5) begin errors++; $display("[TB] FAIL clear_race_setup: got %0h want a5", position); end
    bus_write(A_STATUS, 8'h02);
    checks++; if (position !== 8'hA6) begin errors++; $display("[TB] FAIL clear_race_step: got %0h want a6", position); end
    checks++; if (done_irq !== 1'b1) begin errors++; $display("[TB] FAIL clear_race_set_wins: got %0b want 1", done_irq); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("[TB] FAIL clear_race_status: got %0h want 02", rd); end
  endtask

  task automatic test_random();
    int r, t;
    for (int c = 0; c < 4000 && errors < 20; c++) begin
      r = int'($urandom_range(0, 99));
      w_en = 1'b0; r_en = 1'b0;
      if (r < 2) begin
        t = m_pos + int'($urandom_range(0, 12)) - 6;
        if ($urandom_range(0, 9) == 0) t = ($urandom_range(0, 1) == 0) ? -5 : 300;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        address = A_TARGET; din = 8'(t); w_en = 1'b1;
      end else if (r < 4) begin
        address = A_RATE; din = 8'($urandom_range(0, 2)); w_en = 1'b1;
      end else if (r < 5) begin
        address = A_STATUS; din = 8'($urandom_range(0, 3)); w_en = 1'b1;
      end else if (r < 6) begin
        address = A_POSITION; din = 8'($urandom_range(0, 255)); w_en = 1'b1;
      end else if (r < 16) begin
        address = BASE + 8'($urandom_range(0, 5)); r_en = 1'b1;
      end
      @(negedge clk);
      checks++; if (int'(position) != m_pos) begin errors++; $display("[TB] FAIL rand_position: cycle %0d got %0d want %0d", c, position, m_pos); end
      checks++; if (int'(done_irq) != m_done) begin errors++; $display("[TB] FAIL rand_done: cycle %0d got %0b want %0d", c, done_irq, m_done); end
      checks++; if (int'(dout) != m_dout) begin errors++; $display("[TB] FAIL rand_dout: cycle %0d got %0h want %0h", c, dout, m_dout); end
    end
    w_en = 1'b0; r_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_rate_zero();
    test_retarget();
    test_boundaries();
    test_bus_decode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no finish want finish before 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
